// File: rtl/decode_sequencer_if.sv
// Prefetch FIFO read port plus ModR/M decoder handshake, as seen from the decode sequencer.
interface decode_sequencer_if;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        modrm_start;
  logic        modrm_complete;
  logic        modrm_fifo_rd_en;
  logic        modrm_fifo_empty;
  logic        modrm_immed_start;
  logic        modrm_immed_is_8bit;
  logic        modrm_immed_complete;
  logic [15:0] modrm_immediate;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output modrm_start,
    input  modrm_complete,
    input  modrm_fifo_rd_en,
    output modrm_fifo_empty,
    input  modrm_immed_start,
    input  modrm_immed_is_8bit,
    output modrm_immed_complete,
    output modrm_immediate
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  modrm_start,
    output modrm_complete,
    output modrm_fifo_rd_en,
    input  modrm_fifo_empty,
    output modrm_immed_start,
    output modrm_immed_is_8bit,
    input  modrm_immed_complete,
    input  modrm_immediate
  );
endinterface

// File: rtl/decode_sequencer.sv
// Sequences opcode, ModR/M (+displacement) and immediate fetch over the single FIFO read port.
// Read data returns one cycle after fifo_rd_en; reads stall while fifo_empty; flush aborts to IDLE.
module decode_sequencer #(
  parameter bit DISP8_SIGN_EXTEND = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               flush,
  output logic               busy,
  output logic               complete,
  output logic [7:0]         opcode,
  input  logic               need_modrm,
  input  logic [1:0]         immed_bytes,
  output logic [15:0]        instr_immediate,
  decode_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, OPCODE, DECODE, MODRM, DISP, IMMED, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rd_need, rd_need_nxt, rd_issued, rd_recv;
  logic [1:0]  immed_len, dec_len;
  logic        rd_vld;
  logic        reading, own_rd, data_last;
  logic [7:0]  disp_ext;
  logic [15:0] disp_q;
  logic        immed_done_q;

  // Own byte reader: one outstanding-count pair shared by OPCODE, DISP and IMMED.
  assign reading   = (state == OPCODE) || (state == DISP) || (state == IMMED);
  assign own_rd    = reading && (rd_issued != rd_need) && !bus.fifo_empty && !flush;
  assign data_last = rd_vld && ((rd_recv + 2'd1) == rd_need);
  assign dec_len   = (immed_bytes == 2'd3) ? 2'd2 : immed_bytes;
  assign disp_ext  = (DISP8_SIGN_EXTEND && (rd_need == 2'd1) && bus.fifo_rd_data[7]) ? 8'hFF : 8'h00;

  assign bus.modrm_immed_complete = immed_done_q;
  assign bus.modrm_immediate      = disp_q;

  always_comb begin
    state_nxt            = state;
    rd_need_nxt          = rd_need;
    busy                 = (state != IDLE);
    complete             = (state == DONE) && !flush;
    bus.modrm_start      = (state == MODRM) && !flush && !bus.modrm_complete;
    bus.modrm_fifo_empty = (state == MODRM) ? bus.fifo_empty : 1'b1;
    bus.fifo_rd_en       = (state == MODRM) ? (bus.modrm_fifo_rd_en && !bus.fifo_empty && !flush)
                                            : own_rd;
    case (state)
      IDLE: if (start) begin
        state_nxt   = OPCODE;
        rd_need_nxt = 2'd1;
      end
      OPCODE: if (data_last) state_nxt = DECODE;
      DECODE: begin
        if (need_modrm) begin
          state_nxt = MODRM;
        end else if (dec_len != 2'd0) begin
          state_nxt   = IMMED;
          rd_need_nxt = dec_len;
        end else begin
          state_nxt = DONE;
        end
      end
      MODRM: begin
        if (bus.modrm_complete) begin
          if (immed_len != 2'd0) begin
            state_nxt   = IMMED;
            rd_need_nxt = immed_len;
          end else begin
            state_nxt = DONE;
          end
        end else if (bus.modrm_immed_start && !bus.modrm_immed_complete) begin
          state_nxt   = DISP;
          rd_need_nxt = bus.modrm_immed_is_8bit ? 2'd1 : 2'd2;
        end
      end
      DISP:    if (data_last) state_nxt = MODRM;
      IMMED:   if (data_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rd_need         <= 2'd0;
      rd_issued       <= 2'd0;
      rd_recv         <= 2'd0;
      rd_vld          <= 1'b0;
      immed_len       <= 2'd0;
      opcode          <= 8'h00;
      instr_immediate <= 16'h0000;
      disp_q          <= 16'h0000;
      immed_done_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_need <= rd_need_nxt;
      rd_vld  <= own_rd;
      if (state_nxt != state) begin
        rd_issued <= 2'd0;
        rd_recv   <= 2'd0;
      end else begin
        if (own_rd) rd_issued <= rd_issued + 2'd1;
        if (rd_vld) rd_recv <= rd_recv + 2'd1;
      end
      if (state == DECODE) immed_len <= dec_len;
      if ((state == IDLE) && start && !flush) begin
        instr_immediate <= 16'h0000;
        disp_q          <= 16'h0000;
      end
      // A return landing in the flush cycle belongs to the abandoned instruction.
      if (rd_vld && !flush) begin
        case (state)
          OPCODE: opcode <= bus.fifo_rd_data;
          DISP: begin
            if (rd_recv == 2'd0) disp_q <= {disp_ext, bus.fifo_rd_data};
            else                 disp_q[15:8] <= bus.fifo_rd_data;
          end
          IMMED: begin
            if (rd_recv == 2'd0) instr_immediate <= {8'h00, bus.fifo_rd_data};
            else                 instr_immediate[15:8] <= bus.fifo_rd_data;
          end
          default: ;
        endcase
      end
      if (flush || bus.modrm_complete)     immed_done_q <= 1'b0;
      else if ((state == DISP) && data_last) immed_done_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench: FIFO and ModR/M decoder models; expected results queued at launch, checked on complete.
module tb_decode_sequencer;
  typedef struct {
    logic [7:0]  opc;
    logic [15:0] imm;
    logic [15:0] disp;
    logic [15:0] disp_z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        busy, complete, busy_z, complete_z;
  logic [7:0]  opcode, opcode_z;
  logic        need_modrm;
  logic [1:0]  immed_bytes;
  logic [15:0] instr_immediate, instr_immediate_z;

  decode_sequencer_if bus();
  decode_sequencer_if bus_z();

  decode_sequencer #(.DISP8_SIGN_EXTEND(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .busy(busy), .complete(complete), .opcode(opcode),
    .need_modrm(need_modrm), .immed_bytes(immed_bytes),
    .instr_immediate(instr_immediate), .bus(bus)
  );

  decode_sequencer #(.DISP8_SIGN_EXTEND(1'b0)) dut_z (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .busy(busy_z), .complete(complete_z), .opcode(opcode_z),
    .need_modrm(need_modrm), .immed_bytes(immed_bytes),
    .instr_immediate(instr_immediate_z), .bus(bus_z)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   comp_cnt = 0;
  int   start_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Opcode table
  always_comb begin
    need_modrm  = 1'b0;
    immed_bytes = 2'd0;
    case (opcode)
      8'hB8: immed_bytes = 2'd2;
      8'h04: immed_bytes = 2'd1;
      8'h6A: immed_bytes = 2'd3;
      8'h8B: need_modrm = 1'b1;
      8'hC7: begin need_modrm = 1'b1; immed_bytes = 2'd2; end
      default: ;
    endcase
  end

  // Prefetch FIFO model
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // ModR/M decoder model: read one byte, request displacement by mod/rm, then complete.
  int   m_st;
  logic m_8;
  assign bus.modrm_fifo_rd_en    = (m_st == 1);
  assign bus.modrm_immed_start   = (m_st == 3);
  assign bus.modrm_immed_is_8bit = m_8;
  assign bus.modrm_complete      = (m_st == 4);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 0;
      m_8  <= 1'b0;
    end else if (flush) begin
      m_st <= 0;
    end else begin
      case (m_st)
        0: if (bus.modrm_start) m_st <= 1;
        1: if (!bus.modrm_fifo_empty) m_st <= 2;
        2: begin
          m_8 <= (bus.fifo_rd_data[7:6] == 2'b01);
          if ((bus.fifo_rd_data[7:6] == 2'b01) || (bus.fifo_rd_data[7:6] == 2'b10) ||
              ((bus.fifo_rd_data[7:6] == 2'b00) && (bus.fifo_rd_data[2:0] == 3'b110)))
            m_st <= 3;
          else
            m_st <= 4;
        end
        3: if (bus.modrm_immed_complete) m_st <= 4;
        default: m_st <= 0;
      endcase
    end
  end

  assign bus_z.fifo_rd_data        = bus.fifo_rd_data;
  assign bus_z.fifo_empty          = bus.fifo_empty;
  assign bus_z.modrm_complete      = bus.modrm_complete;
  assign bus_z.modrm_fifo_rd_en    = bus.modrm_fifo_rd_en;
  assign bus_z.modrm_immed_start   = bus.modrm_immed_start;
  assign bus_z.modrm_immed_is_8bit = bus.modrm_immed_is_8bit;

  // Monitor: read accounting and scoreboard compare on complete
  always @(negedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_cnt++;
      check_eq("rd_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
    end
    if (complete) begin
      comp_cnt++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check_eq("opcode", {24'd0, opcode}, {24'd0, mon_e.opc});
        check_eq("instr_imm", {16'd0, instr_immediate}, {16'd0, mon_e.imm});
        check_eq("disp_sext", {16'd0, bus.modrm_immediate}, {16'd0, mon_e.disp});
        check_eq("disp_zext", {16'd0, bus_z.modrm_immediate}, {16'd0, mon_e.disp_z});
        check_eq("complete_z", {31'd0, complete_z}, 32'd1);
        if (mon_e.lat >= 0) check_eq("latency", cyc - start_cyc, mon_e.lat);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    wr_ptr = rd_ptr;
  endtask

  task automatic launch(input logic do_push, input logic [7:0] opc, input logic [15:0] imm,
                        input logic [15:0] disp, input logic [15:0] disp_z, input int lat);
    exp_t e;
    e.opc = opc; e.imm = imm; e.disp = disp; e.disp_z = disp_z; e.lat = lat;
    if (do_push) sb.push_back(e);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    check_eq("done_in_budget", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   r0, c0, n;
    logic found;

    #3;
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_complete", {31'd0, complete}, 0);
    check_eq("rst_opcode", {24'd0, opcode}, 0);
    check_eq("rst_imm", {16'd0, instr_immediate}, 0);
    check_eq("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    check_eq("rst_modrm_start", {31'd0, bus.modrm_start}, 0);
    check_eq("rst_modrm_empty", {31'd0, bus.modrm_fifo_empty}, 1);
    check_eq("rst_immed_cmp", {31'd0, bus.modrm_immed_complete}, 0);
    check_eq("rst_disp", {16'd0, bus.modrm_immediate}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // NOP
    push(8'h90);
    r0 = rd_cnt; c0 = comp_cnt;
    launch(1'b1, 8'h90, 16'h0000, 16'h0000, 16'h0000, 3);
    wait_done(50);
    check_eq("nop_reads", rd_cnt - r0, 1);
    check_eq("nop_completes", comp_cnt - c0, 1);

    // MOV AX,imm16
    push(8'hB8); push(8'h34); push(8'h12);
    r0 = rd_cnt;
    launch(1'b1, 8'hB8, 16'h1234, 16'h0000, 16'h0000, 6);
    wait_done(50);
    check_eq("mov_reads", rd_cnt - r0, 3);

    // ModR/M with disp8
    push(8'h8B); push(8'h46); push(8'hFC);
    r0 = rd_cnt;
    launch(1'b1, 8'h8B, 16'h0000, 16'hFFFC, 16'h00FC, -1);
    wait_done(80);
    check_eq("disp8_reads", rd_cnt - r0, 3);
    check_eq("modrm_start_drop", {31'd0, bus.modrm_start}, 0);

    // ModR/M disp16 + imm16
    push(8'hC7); push(8'h86); push(8'h10); push(8'h00); push(8'h34); push(8'h12);
    r0 = rd_cnt; c0 = comp_cnt;
    launch(1'b1, 8'hC7, 16'h1234, 16'h0010, 16'h0010, -1);
    wait_done(80);
    check_eq("c7_reads", rd_cnt - r0, 6);
    check_eq("c7_completes", comp_cnt - c0, 1);
    check_eq("c7_immed_cmp_clr", {31'd0, bus.modrm_immed_complete}, 0);

    // FIFO empty for 5 cycles between immediate bytes
    push(8'hB8); push(8'h34);
    r0 = rd_cnt;
    launch(1'b1, 8'hB8, 16'h1234, 16'h0000, 16'h0000, 11);
    repeat (9) @(posedge clk);
    #1 push(8'h12);
    wait_done(50);
    check_eq("stall_reads", rd_cnt - r0, 3);

    // imm8 zero-extended; second start while busy ignored
    push(8'h04); push(8'h7F); push(8'h90);
    r0 = rd_cnt; c0 = comp_cnt;
    launch(1'b1, 8'h04, 16'h007F, 16'h0000, 16'h0000, 5);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(50);
    repeat (4) @(posedge clk); #1;
    check_eq("busy_start_reads", rd_cnt - r0, 2);
    check_eq("busy_start_completes", comp_cnt - c0, 1);
    drain();

    // immed_bytes==3 fetches two bytes
    push(8'h6A); push(8'h55); push(8'hAA);
    r0 = rd_cnt;
    launch(1'b1, 8'h6A, 16'hAA55, 16'h0000, 16'h0000, 6);
    wait_done(50);
    check_eq("len3_reads", rd_cnt - r0, 3);

    // flush during DISP
    push(8'h8B); push(8'h46); push(8'hFC);
    r0 = rd_cnt; c0 = comp_cnt;
    launch(1'b0, 8'h8B, 16'h0000, 16'h0000, 16'h0000, -1);
    n = 0; found = 1'b0;
    while (!found && (n < 40)) begin
      @(posedge clk); #1;
      n++;
      if ((m_st == 3) && busy && !bus.modrm_start) found = 1'b1;
    end
    check_eq("disp_reached", {31'd0, found}, 1);
    flush = 1'b1;
    #1;
    check_eq("flush_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    check_eq("flush_complete", {31'd0, complete}, 0);
    @(posedge clk); #1 flush = 1'b0;
    check_eq("flush_idle", {31'd0, busy}, 0);
    check_eq("flush_immed_cmp", {31'd0, bus.modrm_immed_complete}, 0);
    repeat (5) @(posedge clk); #1;
    check_eq("flush_no_complete", comp_cnt - c0, 0);
    check_eq("flush_reads", rd_cnt - r0, 2);
    drain();

    // flush and start together in IDLE
    push(8'h90);
    r0 = rd_cnt;
    @(posedge clk); #1 start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    check_eq("flush_start_idle", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check_eq("flush_start_reads", rd_cnt - r0, 0);
    drain();

    // reset mid-operation
    push(8'hB8); push(8'h34); push(8'h12);
    c0 = comp_cnt;
    launch(1'b0, 8'hB8, 16'h0000, 16'h0000, 16'h0000, -1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 0);
    check_eq("mid_rst_opcode", {24'd0, opcode}, 0);
    check_eq("mid_rst_imm", {16'd0, instr_immediate}, 0);
    check_eq("mid_rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check_eq("mid_rst_no_complete", comp_cnt - c0, 0);
    drain();

    // recovery
    push(8'h90);
    launch(1'b1, 8'h90, 16'h0000, 16'h0000, 16'h0000, 3);
    wait_done(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end
endmodule
